uart_rx_16x: RTL and testbench
==============================

# uart_rx_16x

- UART receiver that recovers 8N1-style frames from an asynchronous serial line.
- Oversamples the line using the one-cycle `clk_16x` enable pulse from `uart_16x_baud`, which runs in the same `clk` domain.
- Validates the start bit at mid-bit, samples each data bit at its centre and checks the stop bit.
- Presents each received word with a one-cycle valid pulse, or flags a framing error.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, sent LSB first, range 5–9.
- `SYNC_STAGES`, 2: synchronizer flops on `rx`, minimum 2.

Ports:
- `clk`  in  1  system clock; the same clock that drives `uart_16x_baud`.
- `rst`  in  1  reset, asynchronous and active-high.
- `clk_16x`  in  1  oversample enable, one `clk` cycle wide, 16 per bit period.
- `rx`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  DATA_BITS  last received word.
- `rx_valid`  out  1  one-cycle pulse when a frame completes with a good stop bit.
- `frame_err`  out  1  one-cycle pulse when the sampled stop bit is 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Synchronization.** `rx` passes through `SYNC_STAGES` flops to give `rx_s`. `rx_prev` captures `rx_s` only on `clk_16x`.
- **Tick gating.** Every state and counter update happens only in cycles where `clk_16x`=1. With no tick, all state holds.
- **Counters.**
  - `os_cnt`, 4 bits: counts ticks within a bit and wraps 15→0.
  - `bit_cnt`: counts 0..DATA_BITS-1.
- **IDLE.**
  - Enter START on a tick where `rx_prev`=1 and `rx_s`=0. Clear `os_cnt`.
  - A line held low, e.g. a break or the tail of an errored frame, never re-arms. A new 1→0 edge is required.
- **START.**
  - On the tick where `os_cnt`=7 (mid start bit), sample `rx_s`.
  - `rx_s`=0: go to DATA with `os_cnt`=0 and `bit_cnt`=0.
  - `rx_s`=1: the edge was a glitch. Return to IDLE with no output pulse.
- **DATA.**
  - On the tick where `os_cnt`=15 (centre of a data bit), shift `rx_s` into the MSB of the shift register (right shift), so bits arrive LSB first.
  - If `bit_cnt`=DATA_BITS-1, go to STOP. Otherwise increment `bit_cnt`.
- **STOP.**
  - On the tick where `os_cnt`=15, load `rx_data` from the shift register, which is always updated, error or not.
  - `rx_s`=1: pulse `rx_valid`.
  - `rx_s`=0: pulse `frame_err`.
  - Then go to IDLE.
- **Simultaneous flags.** `rx_valid` and `frame_err` are never high in the same cycle.
- **Overruns.** Not detected; the consumer must take `rx_data` within one frame time. `rx_data` holds until the next STOP sample.
- **Reset, including mid-frame.** State=IDLE, `os_cnt`=0, `bit_cnt`=0, shift register=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0. Synchronizer flops and `rx_prev` reset to 1, so an idle line does not fake an edge on release.

## Timing
- **Input latency.** `rx` to `rx_s` is `SYNC_STAGES` `clk` cycles. Edge detection adds up to one tick period on top of that.
- **Sample points.**
  - Start bit: 8 ticks after the detect tick.
  - Each data bit: 16 ticks after the previous sample point.
  - Stop bit: sampled at tick 8 + 16·(DATA_BITS+1) after the detect tick.
- **Output pulses.** `rx_valid` and `frame_err` are registered. Each is high for exactly the one `clk` cycle following the stop-sample tick.
- **`rx_data` update.** `rx_data` updates in that same cycle, so it is stable whenever `rx_valid`=1.
- **`busy`.** Rises the cycle after the detect tick and falls with the `rx_valid`/`frame_err` pulse.
- **Back-to-back frames.** The stop-bit centre returns to IDLE. The next start edge arrives about 8 ticks later and is caught, so zero-gap frames are supported.

## Structure
- **Package `uart_pkg`** holds the shared items:
  - state encoding (IDLE, START, DATA, STOP)
  - `OVERSAMPLE`=16
  - `MID_SAMPLE`=7
  - `END_SAMPLE`=15
  - a default `DATA_BITS`=8, so a future `uart_tx_16x` uses the same constants.
- **Sub-module `uart_rx_sync`**: the `SYNC_STAGES` flop chain plus the tick-gated `rx_prev` and falling-edge output. It is reused by any later RX path.
- `uart_rx_16x` instantiates `uart_rx_sync` and contains the FSM and counters.

## Test plan
Defaults: `CLOCK_FREQ`=100 MHz and `BAUDRATE`=625000 on `uart_16x_baud`, giving 10 `clk` per tick and 160 `clk` per bit.
- **Single frame.** Drive 0xA5 (8N1) → exactly one `rx_valid`, `rx_data`=0xA5, `frame_err` stays 0, `busy` high about 1520 `clk`.
- **Start glitch.** Drive `rx` low for 3 ticks, then high → no `rx_valid` or `frame_err`, and the FSM back in IDLE by tick 8.
- **Framing error.** Send 0x3C with stop bit 0 → `frame_err` pulse, `rx_data`=0x3C, no `rx_valid`. Hold the line low for 40 bits → no further pulses. Release, then send 0x55 → `rx_valid` with 0x55.
- **Back-to-back frames.** Send 0x00 then 0xFF with zero idle gap → two `rx_valid` pulses, carrying 0x00 then 0xFF.
- **Reset mid-frame.** Assert `rst` during data bit 4 of a 0x81 frame → outputs cleared immediately and no pulse. After release, a fresh 0x81 → `rx_valid` with 0x81.
- **Baud tolerance.** Drive the serial stimulus at ±3% of the bit period while sending 0x6B → `rx_data`=0x6B and no `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, common to the 16x-oversampled RX and TX paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE        = 16;
  localparam int MID_SAMPLE        = 7;
  localparam int END_SAMPLE        = 15;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Synchronizes the asynchronous serial line and flags a tick-sampled 1->0 transition.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_16x,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev;

  // NOTE: the chain and rx_prev reset to 1 (idle line level) so releasing reset on an idle line never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      if (clk_16x) rx_prev <= rx_s;
    end
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign fall_edge = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_16x.sv
// 16x-oversampling UART receiver: start-bit validation at mid-bit, centre sampling of data and stop bits.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  uart_state_e          state;
  logic [3:0]           os_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_s;
  logic                 fall_edge;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_16x   (clk_16x),
    .rx        (rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle so each is exactly one clk wide, independent of tick spacing.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (clk_16x) begin
        unique case (state)
          IDLE: begin
            if (fall_edge) begin
              state  <= START;
              os_cnt <= '0;
              busy   <= 1'b1;
            end
          end
          START: begin
            if (os_cnt == 4'(MID_SAMPLE)) begin
              os_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          DATA: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'(END_SAMPLE)) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state <= STOP;
              else                                      bit_cnt <= bit_cnt + 1'b1;
            end
          end
          STOP: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'(END_SAMPLE)) begin
              // Word is presented even on a bad stop bit so the consumer can inspect it.
              rx_data   <= shift_q;
              rx_valid  <= rx_s;
              frame_err <= ~rx_s;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: 100 MHz clk, tick every 10 clk, 160 clk per bit.
module tb_uart_rx_16x;

  localparam int BIT_CLKS  = 160;
  localparam int TICK_CLKS = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_16x = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         valid_cnt   = 0;
  int         err_cnt     = 0;
  int         both_cnt    = 0;
  int         busy_cycles = 0;
  logic [7:0] valid_q[$];
  logic [7:0] err_data    = '0;
  int         tick_cnt    = 0;

  uart_rx_16x #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_16x   (clk_16x),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_cnt = (tick_cnt == TICK_CLKS - 1) ? 0 : tick_cnt + 1;
    clk_16x  = (tick_cnt == TICK_CLKS - 1);
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_q.push_back(rx_data);
    end
    if (frame_err) begin
      err_cnt++;
      err_data = rx_data;
    end
    if (rx_valid && frame_err) both_cnt++;
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bit_clks);
    rx = 1'b0;
    idle_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      idle_clks(bit_clks);
    end
    rx = stop_bit;
    idle_clks(bit_clks);
  endtask

  int base_valid, base_err, base_busy, base_q;

  task automatic snap();
    base_valid = valid_cnt;
    base_err   = err_cnt;
    base_busy  = busy_cycles;
    base_q     = valid_q.size();
  endtask

  initial begin
    idle_clks(5);
    check("reset_valid", 32'(rx_valid), 0);
    check("reset_ferr", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_data", 32'(rx_data), 0);
    rst = 1'b0;
    idle_clks(2 * BIT_CLKS);

    // Single frame: busy spans detect tick to stop-sample tick, 152 ticks.
    snap();
    send_frame(8'hA5, 1'b1, BIT_CLKS);
    idle_clks(BIT_CLKS);
    check("single_valid_cnt", 32'(valid_cnt - base_valid), 1);
    check("single_data", 32'(valid_q[base_q]), 32'hA5);
    check("single_ferr_cnt", 32'(err_cnt - base_err), 0);
    check("single_busy_clks", 32'(busy_cycles - base_busy), 1520);
    check("single_busy_end", 32'(busy), 0);

    // Start glitch: 3 ticks low, rejected at the mid-start sample.
    snap();
    rx = 1'b0;
    idle_clks(3 * TICK_CLKS);
    rx = 1'b1;
    idle_clks(12 * TICK_CLKS);
    check("glitch_idle", 32'(busy), 0);
    idle_clks(2 * BIT_CLKS);
    check("glitch_valid_cnt", 32'(valid_cnt - base_valid), 0);
    check("glitch_ferr_cnt", 32'(err_cnt - base_err), 0);
    check("glitch_busy_clks", 32'(busy_cycles - base_busy), 80);

    // Framing error, then a held-low line that must not re-arm.
    snap();
    send_frame(8'h3C, 1'b0, BIT_CLKS);
    check("ferr_cnt", 32'(err_cnt - base_err), 1);
    check("ferr_data", 32'(err_data), 32'h3C);
    check("ferr_no_valid", 32'(valid_cnt - base_valid), 0);
    idle_clks(40 * BIT_CLKS);
    check("break_no_ferr", 32'(err_cnt - base_err), 1);
    check("break_no_valid", 32'(valid_cnt - base_valid), 0);
    check("break_idle", 32'(busy), 0);
    rx = 1'b1;
    idle_clks(2 * BIT_CLKS);
    snap();
    send_frame(8'h55, 1'b1, BIT_CLKS);
    idle_clks(BIT_CLKS);
    check("recover_valid_cnt", 32'(valid_cnt - base_valid), 1);
    check("recover_data", 32'(valid_q[base_q]), 32'h55);

    // Back-to-back frames with zero idle gap.
    snap();
    send_frame(8'h00, 1'b1, BIT_CLKS);
    send_frame(8'hFF, 1'b1, BIT_CLKS);
    idle_clks(BIT_CLKS);
    check("b2b_valid_cnt", 32'(valid_cnt - base_valid), 2);
    check("b2b_data0", 32'(valid_q[base_q]), 32'h00);
    check("b2b_data1", 32'(valid_q[base_q + 1]), 32'hFF);
    check("b2b_ferr_cnt", 32'(err_cnt - base_err), 0);

    // Reset during data bit 4; held until the aborted frame has passed.
    snap();
    fork
      send_frame(8'h81, 1'b1, BIT_CLKS);
      begin
        idle_clks(5 * BIT_CLKS + 50);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_valid", 32'(rx_valid), 0);
      end
    join
    idle_clks(BIT_CLKS);
    rst = 1'b0;
    idle_clks(2 * BIT_CLKS);
    check("rst_no_valid", 32'(valid_cnt - base_valid), 0);
    check("rst_no_ferr", 32'(err_cnt - base_err), 0);
    snap();
    send_frame(8'h81, 1'b1, BIT_CLKS);
    idle_clks(BIT_CLKS);
    check("rst_fresh_cnt", 32'(valid_cnt - base_valid), 1);
    check("rst_fresh_data", 32'(valid_q[base_q]), 32'h81);

    // Baud tolerance: about 3% slow and 3% fast.
    snap();
    send_frame(8'h6B, 1'b1, 165);
    idle_clks(2 * BIT_CLKS);
    send_frame(8'h6B, 1'b1, 155);
    idle_clks(2 * BIT_CLKS);
    check("baud_valid_cnt", 32'(valid_cnt - base_valid), 2);
    check("baud_slow_data", 32'(valid_q[base_q]), 32'h6B);
    check("baud_fast_data", 32'(valid_q[base_q + 1]), 32'h6B);
    check("baud_ferr_cnt", 32'(err_cnt - base_err), 0);

    check("flags_exclusive", 32'(both_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
